compare_serial: RTL and testbench

COMPARE_SERIAL -- requirements
Module: compare_serial

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/adder_n.sv | 18 +
 rtl/slice_cmp.sv | 46 ++++
 rtl/compare_serial.sv | 158 +++++++++++++++
 tb/tb_compare_serial.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg -- shared types for the serial comparator.
//   cmp_op_e    : operation codes accepted on the op port
//   cmp_state_e : controller states, also visible on the dbg_state port
//   idx_width() : width of the slice index register (never below 1 bit)
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_SLTU = 2'b00,
        CMP_SLT  = 2'b01,
        CMP_EQ   = 2'b10,
        CMP_NE   = 2'b11
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cmp_state_e;

    // A single slice still needs a 1-bit index so that the register exists.
    function automatic int idx_width(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/adder_n.sv
// adder_n -- plain W-bit adder with carry in and carry out.
//   a, b : addends
//   cin  : carry in
//   sum  : low W bits of a + b + cin
//   cout : carry out of the top bit
module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/slice_cmp.sv
// slice_cmp -- compares one W-bit slice of two operands.
//   x, y       : slice of the first / second operand
//   signed_top : this is the most significant slice of a signed compare
//   lt         : x < y (unsigned, after the optional sign flip)
//   eq         : x == y
// The compare is the zero-extended subtract x + ~y + 1 done on W+1 bits.
// Bit W of that (W+1)-bit difference is the borrow, and it equals the
// inverse of the carry out of the W-bit adder below, so a W-bit adder is
// enough to produce it.
module slice_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         signed_top,
    output logic         lt,
    output logic         eq
);

    logic [W-1:0] msb_mask;
    logic [W-1:0] xs;
    logic [W-1:0] ys;
    logic [W-1:0] diff;
    logic         carry;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        msb_mask        = '0;
        msb_mask[W-1]   = signed_top;
    end

    assign xs = x ^ msb_mask;
    assign ys = y ^ msb_mask;

    adder_n #(.W(W)) u_sub (
        .a    (xs),
        .b    (~ys),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    assign lt = ~carry;
    assign eq = (diff == '0);

endmodule

// File: rtl/compare_serial.sv
// compare_serial -- multi-cycle comparator that walks the operands one
// SLICE-bit slice per cycle, most significant slice first, and stops at the
// first slice that differs.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake; a, b, op captured on acceptance
//   a, b, op            : operands and operation code (cmp_op_e)
//   out_valid, out_ready: result handshake
//   result              : boolean answer to op
//   lt, eq, gt          : one-hot ordering of a vs b under op's signedness
//   dbg_state           : current controller state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until then;
// in_ready never depends on in_valid, and out_valid/result/lt/eq/gt stay
// stable from the rise of out_valid until the edge where out_ready is seen.
module compare_serial
    import cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output cmp_state_e       dbg_state
);

    localparam int NS    = N / SLICE;
    localparam int IDX_W = idx_width(NS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NS - 1);

    if (N % SLICE != 0) begin : g_bad_slice
        $error("compare_serial: N must be a multiple of SLICE");
    end

    cmp_state_e        state_q;
    cmp_state_e        state_d;
    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;
    cmp_op_e           op_q;
    logic [IDX_W-1:0]  idx_q;
    logic              lt_q;
    logic              eq_q;
    logic              gt_q;
    // Held low through reset and set by the first edge after release, so
    // in_ready stays 0 while rst_n is low even though the state is IDLE.
    logic              alive_q;

    logic              accept;
    logic              s_lt;
    logic              s_eq;
    logic              signed_top;

    assign accept = in_valid && in_ready;

    // The operand registers shift left after each equal slice, so the slice
    // under test is always the top SLICE bits.
    assign signed_top = (op_q == CMP_SLT) && (idx_q == IDX_TOP);

    slice_cmp #(.W(SLICE)) u_slice (
        .x          (a_q[N-1 -: SLICE]),
        .y          (b_q[N-1 -: SLICE]),
        .signed_top (signed_top),
        .lt         (s_lt),
        .eq         (s_eq)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (!s_eq || idx_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: everything is forced to 0 outside DONE.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && alive_q;
        out_valid = 1'b0;
        result    = 1'b0;
        lt        = 1'b0;
        eq        = 1'b0;
        gt        = 1'b0;
        if (state_q == ST_DONE) begin
            out_valid = 1'b1;
            lt        = lt_q;
            eq        = eq_q;
            gt        = gt_q;
            unique case (op_q)
                CMP_SLTU, CMP_SLT: result = lt_q;
                CMP_EQ:            result = eq_q;
                CMP_NE:            result = ~eq_q;
                default:           result = 1'b0;
            endcase
        end
    end

    assign dbg_state = state_q;

    // Datapath: operand capture, slice walk and ordering flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= CMP_SLTU;
            idx_q <= '0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= cmp_op_e'(op);
                idx_q <= IDX_TOP;
                lt_q  <= 1'b0;
                eq_q  <= 1'b0;
                gt_q  <= 1'b0;
            end else if (state_q == ST_RUN) begin
                if (!s_eq) begin
                    lt_q <= s_lt;
                    gt_q <= ~s_lt;
                end else if (idx_q == '0) begin
                    eq_q <= 1'b1;
                end else begin
                    idx_q <= idx_q - 1'b1;
                    a_q   <= a_q << SLICE;
                    b_q   <= b_q << SLICE;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial -- randomized self-checking bench for compare_serial.
// A 32-bit/8-bit-slice instance and a single-slice 8-bit instance share
// the stimulus; expected answers come from whole-word arithmetic.
module tb_compare_serial;
    import cmp_pkg::*;

    localparam int NS = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;

    logic        in_ready, out_valid, result, lt, eq, gt;
    cmp_state_e  dbg_state;
    logic        in_ready8, out_valid8, result8, lt8, eq8, gt8;
    cmp_state_e  dbg_state8;

    int          checks = 0;
    int          errors = 0;

    // Expected record: {result, lt, eq, gt, k[3:0]}
    logic [7:0]  exp_q[$];
    logic [7:0]  exp8_q[$];

    compare_serial #(.N(32), .SLICE(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .dbg_state (dbg_state)
    );

    compare_serial #(.N(8), .SLICE(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .op        (op),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .result    (result8),
        .lt        (lt8),
        .eq        (eq8),
        .gt        (gt8),
        .dbg_state (dbg_state8)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ordering from whole-word compares, k = slices examined
    // until the first differing one (or all of them).
    function automatic logic [7:0] model32(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] o);
        logic is_lt, is_eq, res;
        int   k;
        is_eq = (x == y);
        is_lt = (o == CMP_SLT) ? ($signed(x) < $signed(y)) : (x < y);
        k = NS;
        for (int s = NS - 1; s >= 0; s--) begin
            if (((x >> (8 * s)) & 32'hFF) != ((y >> (8 * s)) & 32'hFF)) begin
                k = NS - s;
                break;
            end
        end
        case (o)
            CMP_EQ:  res = is_eq;
            CMP_NE:  res = !is_eq;
            default: res = is_lt;
        endcase
        return {res, is_lt, is_eq, !is_lt && !is_eq, 4'(k)};
    endfunction

    function automatic logic [7:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic [1:0] o);
        logic is_lt, is_eq, res;
        is_eq = (x == y);
        is_lt = (o == CMP_SLT) ? ($signed(x) < $signed(y)) : (x < y);
        case (o)
            CMP_EQ:  res = is_eq;
            CMP_NE:  res = !is_eq;
            default: res = is_lt;
        endcase
        return {res, is_lt, is_eq, !is_lt && !is_eq, 4'd1};
    endfunction

    // ---------------- driver ----------------
    // Issues one request, measures latency, holds the result for `hold`
    // cycles with stray in_valid pulses, then completes the handshake.
    task automatic do_req(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [1:0] top, input int hold);
        logic [7:0] e;
        logic [7:0] e8;
        int         w;
        int         cyc;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_req", in_ready, 1);
        exp_q.push_back(model32(ta, tb_v, top));
        exp8_q.push_back(model8(ta[7:0], tb_v[7:0], top));

        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        check("out_valid_after_accept", out_valid, 0);
        check("in_ready_after_accept", in_ready, 0);

        cyc = 0;
        while (!out_valid && cyc < NS + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        e  = exp_q.pop_front();
        e8 = exp8_q.pop_front();
        check("latency_k", cyc, {28'd0, e[3:0]});
        check("result", result, e[7]);
        check("lt_eq_gt", {lt, eq, gt}, e[6:4]);
        check("onehot", 32'(lt) + 32'(eq) + 32'(gt), 1);
        check("n8_valid", out_valid8, 1);
        check("n8_result", result8, e8[7]);
        check("n8_lt_eq_gt", {lt8, eq8, gt8}, e8[6:4]);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, e[7]);
            check("hold_lt_eq_gt", {lt, eq, gt}, e[6:4]);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("flags_after_hs", {result, lt, eq, gt}, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", {result, lt, eq, gt}, 0);
        check("rst_n8", {in_ready8, out_valid8}, 0);
        @(posedge clk); #1;
        check("rst_in_ready_edge", in_ready, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1);

        // Directed cases
        do_req(32'h0000_0001, 32'hFFFF_FFFF, CMP_SLTU, 0);
        do_req(32'h0000_0001, 32'hFFFF_FFFF, CMP_SLT,  0);
        do_req(32'h8000_0000, 32'h7FFF_FFFF, CMP_SLT,  1);
        do_req(32'h1234_5677, 32'h1234_5678, CMP_SLTU, 0);
        do_req(32'hDEAD_BEEF, 32'hDEAD_BEEF, CMP_EQ,   5);
        do_req(32'hDEAD_BEEF, 32'hDEAD_BEEF, CMP_NE,   0);
        do_req(32'h1234_5678, 32'h1234_5677, CMP_SLT,  2);

        // Reset in the middle of RUN
        ra = $urandom;
        a = ra; b = ra; op = CMP_SLTU; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midrun_out_valid", out_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", in_ready, 0);
        check("midrun_rst_out", {out_valid, result, lt, eq, gt}, 0);
        check("midrun_rst_n8", {out_valid8, in_ready8}, 0);
        @(posedge clk); #1;
        check("midrun_rst_hold", out_valid, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrun_release_ready", in_ready, 1);
        check("midrun_release_valid", out_valid, 0);
        do_req(32'hCAFE_0000, 32'hCAFE_0000, CMP_SLTU, 0);

        // Randomized requests
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
            endcase
            do_req(ra, rb, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
